dpwm: RTL and testbench



---
 rtl/dpwm_if.sv | 22 ++
 rtl/dpwm.sv | 241 ++++++++++++++++++++++++
 tb/tb_dpwm.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dpwm_if.sv
// dpwm_if: board-side pins of the dpwm block (buttons, switches, gate outputs, display).
// The DUT connects through the slave modport; the driving side (top level or bench) uses master.
interface dpwm_if;
  logic       boton_aumentar;
  logic       boton_disminuir;
  logic       seleccion_funcion;
  logic       seleccion_salida;
  logic       BUCK_Gate;
  logic       Full_Bridge;
  logic [3:0] anodos_7seg;
  logic [7:0] catodos_7seg;

  modport slave (
    input  boton_aumentar, boton_disminuir, seleccion_funcion, seleccion_salida,
    output BUCK_Gate, Full_Bridge, anodos_7seg, catodos_7seg
  );

  modport master (
    output boton_aumentar, boton_disminuir, seleccion_funcion, seleccion_salida,
    input  BUCK_Gate, Full_Bridge, anodos_7seg, catodos_7seg
  );
endinterface

// File: rtl/dpwm.sv
// dpwm: push-button adjustable PWM generator with 4-digit multiplexed 7-segment readout.
// Buttons step either the duty (percent) or the frequency index; the PWM is routed to the
// buck gate or the full bridge by a switch. New settings take effect only at a period wrap.
// Optional feature: define DPWM_AUTOREPEAT_EN to emit repeated steps while a button is held.
module dpwm #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DUTY_STEP       = 10,
  parameter int REFRESH_BITS    = 16,
  parameter int REPEAT_CYCLES   = 50000000
) (
  input logic CLK_FPGA_BOARD,
  input logic reinicio,
  dpwm_if.slave io
);

  localparam int          DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [6:0]  STEP  = 7'(DUTY_STEP);
  localparam logic [3:0]  BLANK = 4'hF;

  // ---------------------------------------------------------------- button path
  // Index 0 = aumentar (up), index 1 = disminuir (down).
  logic [1:0]           btn_pin;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           level_q, level_d, level_prev_q;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           step_pulse;

  assign btn_pin = {io.boton_disminuir, io.boton_aumentar};

  // Debounce: accept the synchronized level after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    level_d  = level_q;
    db_cnt_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != level_q[b]) begin
        if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // Synchronizer, debounce counter and accepted-level registers.
  always_ff @(posedge CLK_FPGA_BOARD or posedge reinicio) begin
    // NOTE: state is updated with <= so every register samples pre-edge values, order-independent.
    if (reinicio) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      db_cnt_q     <= '0;
    end else begin
      sync1_q      <= btn_pin;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      db_cnt_q     <= db_cnt_d;
    end
  end

`ifdef DPWM_AUTOREPEAT_EN
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  logic [1:0][RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [1:0]           rep_pulse;

  // Auto-repeat: while a level stays accepted high, pulse every REPEAT_CYCLES clocks.
  always_comb begin
    rep_cnt_d = '0;
    rep_pulse = '0;
    for (int b = 0; b < 2; b++) begin
      if (level_q[b] && level_prev_q[b]) begin
        if (rep_cnt_q[b] == RP_W'(REPEAT_CYCLES - 1)) begin
          rep_pulse[b] = 1'b1;
        end else begin
          rep_cnt_d[b] = rep_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // Auto-repeat counter registers.
  always_ff @(posedge CLK_FPGA_BOARD or posedge reinicio) begin
    if (reinicio) rep_cnt_q <= '0;
    else          rep_cnt_q <= rep_cnt_d;
  end

  assign step_pulse = (level_q & ~level_prev_q) | rep_pulse;
`else
  assign step_pulse = level_q & ~level_prev_q;
`endif

  // ---------------------------------------------------------------- adjusted settings
  logic       step_up, step_dn;
  logic [6:0] duty_q, duty_d;
  logic [1:0] freq_idx_q, freq_idx_d;

  // Simultaneous pulses on both buttons cancel each other.
  assign step_up = step_pulse[0] & ~step_pulse[1];
  assign step_dn = step_pulse[1] & ~step_pulse[0];

  // Saturating step of duty or frequency index, chosen by the function switch.
  always_comb begin
    duty_d     = duty_q;
    freq_idx_d = freq_idx_q;
    if (!io.seleccion_funcion) begin
      if (step_up)      duty_d = (duty_q > 7'd100 - STEP) ? 7'd100 : duty_q + STEP;
      else if (step_dn) duty_d = (duty_q < STEP) ? 7'd0 : duty_q - STEP;
    end else begin
      if (step_up && freq_idx_q != 2'd3)      freq_idx_d = freq_idx_q + 2'd1;
      else if (step_dn && freq_idx_q != 2'd0) freq_idx_d = freq_idx_q - 2'd1;
    end
  end

  // Adjusted-setting registers.
  always_ff @(posedge CLK_FPGA_BOARD or posedge reinicio) begin
    if (reinicio) begin
      duty_q     <= 7'd50;
      freq_idx_q <= 2'd0;
    end else begin
      duty_q     <= duty_d;
      freq_idx_q <= freq_idx_d;
    end
  end

  // ---------------------------------------------------------------- PWM engine
  logic [2:0] presc_q, presc_d, div_max;
  logic [6:0] phase_q, phase_d;
  logic [6:0] duty_act_q, duty_act_d;
  logic [1:0] freq_act_q, freq_act_d;
  logic       tick, wrap, pwm_level;
  logic       buck_q, buck_d, full_q, full_d;

  // Prescaler, phase counter, wrap-aligned reload and routed output levels.
  always_comb begin
    unique case (freq_act_q)
      2'd0:    div_max = 3'd0;
      2'd1:    div_max = 3'd1;
      2'd2:    div_max = 3'd3;
      default: div_max = 3'd7;
    endcase
    tick       = (presc_q == div_max);
    wrap       = tick && (phase_q == 7'd99);
    presc_d    = tick ? 3'd0 : presc_q + 3'd1;
    phase_d    = phase_q;
    duty_act_d = duty_act_q;
    freq_act_d = freq_act_q;
    if (tick) phase_d = wrap ? 7'd0 : phase_q + 7'd1;
    // Reload only at the wrap so a period is never cut short.
    if (wrap) begin
      duty_act_d = duty_q;
      freq_act_d = freq_idx_q;
    end
    pwm_level = (phase_q < duty_act_q);
    buck_d    = pwm_level & ~io.seleccion_salida;
    full_d    = pwm_level &  io.seleccion_salida;
  end

  // PWM state and registered gate outputs.
  always_ff @(posedge CLK_FPGA_BOARD or posedge reinicio) begin
    if (reinicio) begin
      presc_q    <= '0;
      phase_q    <= '0;
      duty_act_q <= 7'd50;
      freq_act_q <= 2'd0;
      buck_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      duty_act_q <= duty_act_d;
      freq_act_q <= freq_act_d;
      buck_q     <= buck_d;
      full_q     <= full_d;
    end
  end

  assign io.BUCK_Gate   = buck_q;
  assign io.Full_Bridge = full_q;

  // ---------------------------------------------------------------- display
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]              digit_sel;
  logic [3:0][3:0]         digits;
  logic [3:0]              code;
  logic [3:0]              anodes_q, anodes_d;
  logic [7:0]              cathodes_q, cathodes_d;

  assign digit_sel = refresh_q[REFRESH_BITS-1 -: 2];

  // Digit codes for the selected value, then glyph lookup for the active digit.
  always_comb begin
    digits = {4{BLANK}};
    if (!io.seleccion_funcion) begin
      digits[2] = (duty_q >= 7'd100) ? 4'd1 : BLANK;
      digits[1] = (duty_q >= 7'd10) ? 4'((duty_q % 7'd100) / 7'd10) : BLANK;
      digits[0] = 4'(duty_q % 7'd10);
    end else begin
      unique case (freq_idx_q)
        2'd0:    digits = {4'd1, 4'd0, 4'd0, 4'd0};
        2'd1:    digits = {BLANK, 4'd5, 4'd0, 4'd0};
        2'd2:    digits = {BLANK, 4'd2, 4'd5, 4'd0};
        default: digits = {BLANK, 4'd1, 4'd2, 4'd5};
      endcase
    end
    code     = digits[digit_sel];
    anodes_d = ~(4'b0001 << digit_sel);
    unique case (code)
      4'd0:    cathodes_d = 8'hC0;
      4'd1:    cathodes_d = 8'hF9;
      4'd2:    cathodes_d = 8'hA4;
      4'd3:    cathodes_d = 8'hB0;
      4'd4:    cathodes_d = 8'h99;
      4'd5:    cathodes_d = 8'h92;
      4'd6:    cathodes_d = 8'h82;
      4'd7:    cathodes_d = 8'hF8;
      4'd8:    cathodes_d = 8'h80;
      4'd9:    cathodes_d = 8'h90;
      default: cathodes_d = 8'hFF;
    endcase
  end

  // Refresh counter and registered display drivers.
  always_ff @(posedge CLK_FPGA_BOARD or posedge reinicio) begin
    if (reinicio) begin
      refresh_q  <= '0;
      anodes_q   <= 4'b1111;
      cathodes_q <= 8'hFF;
    end else begin
      refresh_q  <= refresh_q + 1'b1;
      anodes_q   <= anodes_d;
      cathodes_q <= cathodes_d;
    end
  end

  assign io.anodos_7seg  = anodes_q;
  assign io.catodos_7seg = cathodes_q;

endmodule

// File: tb/tb_dpwm.sv
// tb_dpwm: directed bench for dpwm with hand-computed duty counts, periods and display glyphs.
// Uses a short refresh counter so all four digits are scanned quickly.
module tb_dpwm;
  localparam int RB = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  dpwm_if bus ();

  dpwm #(
    .DEBOUNCE_CYCLES(16),
    .DUTY_STEP      (10),
    .REFRESH_BITS   (RB),
    .REPEAT_CYCLES  (50000000)
  ) dut (
    .CLK_FPGA_BOARD(clk),
    .reinicio      (rst),
    .io            (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic out_sig(input bit full);
    return full ? bus.Full_Bridge : bus.BUCK_Gate;
  endfunction

  // Hold long enough to be accepted, release long enough to be accepted low again.
  task automatic press(input bit up, input bit dn);
    @(negedge clk);
    bus.boton_aumentar  = up;
    bus.boton_disminuir = dn;
    cyc(40);
    bus.boton_aumentar  = 1'b0;
    bus.boton_disminuir = 1'b0;
    cyc(30);
  endtask

  task automatic press_n(input bit up, input int n);
    for (int k = 0; k < n; k++) press(up, !up);
  endtask

  task automatic count_high(input bit full, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (out_sig(full) === 1'b1) cnt++;
    end
  endtask

  // Cycles between two rising edges; -1 when an edge does not arrive in time.
  task automatic period(input bit full, output int p);
    logic prev;
    int   k;
    p = -1;
    @(negedge clk);
    prev = out_sig(full);
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (out_sig(full) && !prev) break;
      prev = out_sig(full);
    end
    if (k == 3000) return;
    prev = 1'b1;
    for (k = 1; k <= 3000; k++) begin
      @(negedge clk);
      if (out_sig(full) && !prev) begin
        p = k;
        return;
      end
      prev = out_sig(full);
    end
  endtask

  // Wait for each digit's anode in turn and check its glyph (e3 = leftmost).
  task automatic show(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                      input logic [7:0] e1, input logic [7:0] e0);
    logic [7:0] exp_seg [4];
    logic [3:0] an_exp;
    int         k;
    exp_seg = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      an_exp = 4'(~(4'b0001 << i));
      for (k = 0; k < 400; k++) begin
        @(negedge clk);
        if (bus.anodos_7seg == an_exp) break;
      end
      if (k == 400) check($sformatf("%s_anode%0d", tag, i), {28'd0, bus.anodos_7seg}, {28'd0, an_exp});
      else          check($sformatf("%s_dig%0d", tag, i), {24'd0, bus.catodos_7seg}, {24'd0, exp_seg[i]});
    end
  endtask

  int cnt;
  int per;
  int k;

  initial begin
    bus.boton_aumentar    = 1'b0;
    bus.boton_disminuir   = 1'b0;
    bus.seleccion_funcion = 1'b0;
    bus.seleccion_salida  = 1'b0;

    // Reset state.
    cyc(10);
    check("rst_buck", {31'd0, bus.BUCK_Gate}, 32'd0);
    check("rst_full", {31'd0, bus.Full_Bridge}, 32'd0);
    check("rst_anodes", {28'd0, bus.anodos_7seg}, 32'hF);
    check("rst_cathodes", {24'd0, bus.catodos_7seg}, 32'hFF);
    rst = 1'b0;

    // Default 50 % at 1 MHz on the buck output.
    cyc(250);
    count_high(1'b0, 100, cnt); check("duty50_buck", cnt, 50);
    count_high(1'b1, 100, cnt); check("duty50_full", cnt, 0);
    period(1'b0, per);          check("period_idx0", per, 100);
    show("disp50", 8'hFF, 8'hFF, 8'h92, 8'hC0);

    // Three increments: 60, 70, 80.
    press_n(1'b1, 3);
    cyc(250);
    count_high(1'b0, 100, cnt); check("duty80_buck", cnt, 80);
    show("disp80", 8'hFF, 8'hFF, 8'h80, 8'hC0);

    // Ten decrements from 80 saturate at 0.
    press_n(1'b0, 10);
    cyc(250);
    count_high(1'b0, 200, cnt); check("duty0_buck", cnt, 0);
    show("disp0", 8'hFF, 8'hFF, 8'hFF, 8'hC0);

    // Fifteen increments saturate at 100.
    press_n(1'b1, 15);
    cyc(250);
    count_high(1'b0, 200, cnt); check("duty100_buck", cnt, 200);
    show("disp100", 8'hFF, 8'hF9, 8'hC0, 8'hC0);

    // Back to 50.
    press_n(1'b0, 5);
    cyc(250);
    count_high(1'b0, 100, cnt); check("duty50_again", cnt, 50);

    // Frequency adjustment.
    bus.seleccion_funcion = 1'b1;
    show("disp1000", 8'hF9, 8'hC0, 8'hC0, 8'hC0);
    press_n(1'b1, 2);
    cyc(1000);
    period(1'b0, per);          check("period_idx2", per, 400);
    show("disp250", 8'hFF, 8'hA4, 8'h92, 8'hC0);
    press_n(1'b1, 2);
    cyc(2000);
    period(1'b0, per);          check("period_idx3", per, 800);
    count_high(1'b0, 800, cnt); check("duty50_idx3", cnt, 400);
    show("disp125", 8'hFF, 8'hF9, 8'hA4, 8'h92);

    // Route to the full bridge: buck must drop after one clock.
    @(negedge clk);
    bus.seleccion_salida = 1'b1;
    @(posedge clk); #1;
    check("switch_buck_off", {31'd0, bus.BUCK_Gate}, 32'd0);
    count_high(1'b1, 800, cnt); check("full_duty", cnt, 400);
    count_high(1'b0, 800, cnt); check("buck_held0", cnt, 0);

    // Both buttons together change nothing, in either function.
    press(1'b1, 1'b1);
    show("both_freq", 8'hFF, 8'hF9, 8'hA4, 8'h92);
    bus.seleccion_funcion = 1'b0;
    press(1'b1, 1'b1);
    show("both_duty", 8'hFF, 8'hFF, 8'h92, 8'hC0);
    period(1'b1, per);          check("both_period", per, 800);

    // Reset mid-period while the full bridge is high.
    press_n(1'b1, 2);
    cyc(2000);
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bus.Full_Bridge) break;
    end
    check("pre_reset_high", {31'd0, bus.Full_Bridge}, 32'd1);
    cyc(3);
    rst = 1'b1;
    #1;
    check("midrst_full", {31'd0, bus.Full_Bridge}, 32'd0);
    check("midrst_buck", {31'd0, bus.BUCK_Gate}, 32'd0);
    check("midrst_anodes", {28'd0, bus.anodos_7seg}, 32'hF);
    check("midrst_cathodes", {24'd0, bus.catodos_7seg}, 32'hFF);
    cyc(5);
    rst = 1'b0;
    cyc(250);
    count_high(1'b1, 100, cnt); check("post_rst_duty", cnt, 50);
    period(1'b1, per);          check("post_rst_period", per, 100);
    show("post_rst_disp", 8'hFF, 8'hFF, 8'h92, 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
